// File: rtl/orv64_pmp_region_checker.sv
// -----------------------------------------------------------------------------
// orv64_pmp_region_checker
//
// Physical-memory-protection checker for the ORV64 core. It holds NUM_ENTRIES
// pmpcfg/pmpaddr pairs, written by the CSR file. After every effective write
// it walks all entries, one per cycle, and precomputes an inclusive
// [base, limit] byte range for each one (OFF/TOR/NA4/NAPOT). In IDLE it
// answers permission queries from the fetch/LSU path. Each answer appears one
// cycle after the query is accepted.
//
// Ports
//   i_clk, i_rstn                     clock, asynchronous active-low reset
//   i_wr_valid / o_wr_ready           CSR write handshake
//   i_wr_sel                          0 = cfg byte, 1 = pmpaddr
//   i_wr_idx, i_wr_data               entry index and write data
//   i_req_valid / o_req_ready         query handshake
//   i_req_addr                        physical byte address
//   i_req_type                        0 load, 1 store, 2 fetch, 3 always denied
//   i_req_priv_m                      requester runs in M-mode
//   o_resp_valid                      one-cycle pulse per accepted query
//   o_resp_allow, o_resp_matched      verdict and "some entry matched"
//   o_resp_idx                        lowest matching entry (0 if none)
// -----------------------------------------------------------------------------
module orv64_pmp_region_checker #(
    parameter int NUM_ENTRIES = 16,
    parameter int PADDR_WIDTH = 56,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic                   i_wr_sel,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  logic [63:0]            i_wr_data,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [PADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]             i_req_type,
    input  logic                   i_req_priv_m,
    output logic                   o_resp_valid,
    output logic                   o_resp_allow,
    output logic                   o_resp_matched,
    output logic [IDX_W-1:0]       o_resp_idx
);
    localparam int AW = PADDR_WIDTH - 2;

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_k;
    logic                   r_ready;
    logic [7:0]             r_cfg   [NUM_ENTRIES];
    logic [AW-1:0]          r_addr  [NUM_ENTRIES];
    logic [PADDR_WIDTH-1:0] r_base  [NUM_ENTRIES];
    logic [PADDR_WIDTH-1:0] r_limit [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_rv;

    logic                   r_resp_valid;
    logic                   r_resp_allow;
    logic                   r_resp_matched;
    logic [IDX_W-1:0]       r_resp_idx;

    // ---------------- write port ----------------
    logic             w_wr_fire;
    logic             w_wr_eff;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_lock_next;
    logic [7:0]       w_cfg_wdata;

    assign w_wr_fire  = i_wr_valid && r_ready;
    assign w_next_idx = i_wr_idx + IDX_W'(1);
    // A locked TOR entry also freezes the pmpaddr below it (its lower bound).
    assign w_lock_next = (i_wr_idx != IDX_W'(NUM_ENTRIES - 1)) &&
                         r_cfg[w_next_idx][7] && (r_cfg[w_next_idx][4:3] == 2'b01);
    assign w_wr_eff   = w_wr_fire && !r_cfg[i_wr_idx][7] && !(i_wr_sel && w_lock_next);
    // Reserved bits read as zero; W is only kept when R is set.
    assign w_cfg_wdata = {i_wr_data[7], 2'b00, i_wr_data[4:3], i_wr_data[2],
                          i_wr_data[1] & i_wr_data[0], i_wr_data[0]};

    // ---------------- range computation for entry r_k ----------------
    logic [IDX_W-1:0]       w_prev_idx;
    logic [PADDR_WIDTH-1:0] w_a, w_lo, w_t, w_mask;
    logic                   w_calc_rv;
    logic [PADDR_WIDTH-1:0] w_calc_base, w_calc_limit;

    assign w_prev_idx = r_k - IDX_W'(1);
    assign w_a        = {r_addr[r_k], 2'b00};
    assign w_lo       = (r_k == '0) ? '0 : {r_addr[w_prev_idx], 2'b00};
    assign w_t        = {r_addr[r_k], 2'b11};
    // t ^ (t+1) sets bits [p:0], p being the lowest zero of t; all ones if t is all ones.
    assign w_mask     = w_t ^ (w_t + PADDR_WIDTH'(1));

    always_comb begin
        w_calc_rv    = 1'b0;
        w_calc_base  = '0;
        w_calc_limit = '0;
        unique case (r_cfg[r_k][4:3])
            2'b01: begin
                w_calc_rv    = (w_lo < w_a);
                w_calc_base  = w_lo;
                w_calc_limit = w_a - PADDR_WIDTH'(1);
            end
            2'b10: begin
                w_calc_rv    = 1'b1;
                w_calc_base  = w_a;
                w_calc_limit = w_a + PADDR_WIDTH'(3);
            end
            2'b11: begin
                w_calc_rv    = 1'b1;
                w_calc_base  = w_t & ~w_mask;
                w_calc_limit = w_t | w_mask;
            end
            default: ;
        endcase
    end

    // ---------------- FSM and table ----------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_ready <= 1'b1;
            r_rv    <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_cfg[i]   <= '0;
                r_addr[i]  <= '0;
                r_base[i]  <= '0;
                r_limit[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_wr_eff) begin
                        r_state <= S_CALC;
                        r_ready <= 1'b0;
                        r_k     <= '0;
                        if (i_wr_sel) r_addr[i_wr_idx] <= i_wr_data[AW-1:0];
                        else          r_cfg[i_wr_idx]  <= w_cfg_wdata;
                    end
                end
                S_CALC: begin
                    r_rv[r_k]    <= w_calc_rv;
                    r_base[r_k]  <= w_calc_base;
                    r_limit[r_k] <= w_calc_limit;
                    if (r_k == IDX_W'(NUM_ENTRIES - 1)) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + IDX_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- query path ----------------
    logic [NUM_ENTRIES-1:0] w_hit;
    logic [NUM_ENTRIES-1:0] w_off;
    logic                   w_matched;
    logic [IDX_W-1:0]       w_match_idx;
    logic [7:0]             w_sel_cfg;
    logic                   w_perm;
    logic                   w_allow;
    logic                   w_req_fire;

    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
        assign w_hit[gi] = r_rv[gi] && (i_req_addr >= r_base[gi]) && (i_req_addr <= r_limit[gi]);
        assign w_off[gi] = (r_cfg[gi][4:3] == 2'b00);
    end

    // Lowest index wins: scan downwards so the last assignment is the lowest hit.
    always_comb begin
        w_matched   = 1'b0;
        w_match_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_matched   = 1'b1;
                w_match_idx = IDX_W'(i);
            end
        end
    end

    assign w_sel_cfg  = r_cfg[w_match_idx];
    assign w_perm     = (i_req_type == 2'd3) ? 1'b0 : w_sel_cfg[i_req_type];
    assign w_req_fire = i_req_valid && r_ready;

    always_comb begin
        w_allow = 1'b0;
        if (i_req_type == 2'd3)  w_allow = 1'b0;
        else if (w_matched)      w_allow = w_sel_cfg[7] ? w_perm : (i_req_priv_m || w_perm);
        else                     w_allow = i_req_priv_m || (&w_off);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_resp_valid   <= 1'b0;
            r_resp_allow   <= 1'b0;
            r_resp_matched <= 1'b0;
            r_resp_idx     <= '0;
        end else begin
            r_resp_valid <= w_req_fire;
            if (w_req_fire) begin
                r_resp_allow   <= w_allow;
                r_resp_matched <= w_matched;
                r_resp_idx     <= w_match_idx;
            end
        end
    end

    assign o_wr_ready     = r_ready;
    assign o_req_ready    = r_ready;
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_allow   = r_resp_allow;
    assign o_resp_matched = r_resp_matched;
    assign o_resp_idx     = r_resp_idx;

endmodule

// File: tb/tb_orv64_pmp_region_checker.sv
// -----------------------------------------------------------------------------
// tb_orv64_pmp_region_checker
//
// Bench for orv64_pmp_region_checker (16 entries, 56-bit addresses).
// A table of directed writes and queries runs first. Hand-written sequences
// follow for a write and a query in the same cycle, the stall of the next
// query, and a reset during CALC. A randomized phase comes last and checks
// results against a range/permission model of the PMP rules.
// -----------------------------------------------------------------------------
module tb_orv64_pmp_region_checker;
    localparam int N  = 16;
    localparam int W  = 56;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_valid, wr_ready, wr_sel;
    logic [IW-1:0] wr_idx;
    logic [63:0]   wr_data;
    logic          req_valid, req_ready;
    logic [W-1:0]  req_addr;
    logic [1:0]    req_type;
    logic          req_priv_m;
    logic          resp_valid, resp_allow, resp_matched;
    logic [IW-1:0] resp_idx;

    always #5 clk = ~clk;

    orv64_pmp_region_checker #(.NUM_ENTRIES(N), .PADDR_WIDTH(W)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_sel(wr_sel),
        .i_wr_idx(wr_idx), .i_wr_data(wr_data),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
        .i_req_type(req_type), .i_req_priv_m(req_priv_m),
        .o_resp_valid(resp_valid), .o_resp_allow(resp_allow),
        .o_resp_matched(resp_matched), .o_resp_idx(resp_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_cfg  [N];
    logic [63:0] m_addr [N];

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_cfg[i]  = '0;
            m_addr[i] = '0;
        end
    endfunction

    function automatic bit m_write(input bit sel, input int idx, input logic [63:0] d);
        if (m_cfg[idx][7]) return 1'b0;
        if (sel && idx + 1 < N && m_cfg[idx+1][7] && m_cfg[idx+1][4:3] == 2'd1) return 1'b0;
        if (sel) m_addr[idx] = d & ((64'd1 << (W - 2)) - 1);
        else     m_cfg[idx]  = {d[7], 2'b00, d[4:3], d[2], d[1] & d[0], d[0]};
        return 1'b1;
    endfunction

    function automatic void m_range(input int i, output bit v, output logic [63:0] b,
                                    output logic [63:0] l);
        logic [63:0] a, t, sz, lo;
        int n;
        a = m_addr[i] * 4;
        v = 1'b0; b = '0; l = '0;
        case (m_cfg[i][4:3])
            2'd1: begin
                lo = 0;
                if (i > 0) lo = m_addr[i-1] * 4;
                v = (lo < a); b = lo; l = a - 1;
            end
            2'd2: begin v = 1'b1; b = a; l = a + 3; end
            2'd3: begin
                t = a + 3;
                n = 0;
                while (n < W && t[n]) n++;
                v = 1'b1;
                if (n >= W) begin
                    b = 0; l = (64'd1 << W) - 1;
                end else begin
                    sz = 64'd1 << (n + 1);
                    b  = (t / sz) * sz;
                    l  = b + sz - 1;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void m_query(input logic [63:0] addr, input int typ, input bit priv,
                                    output bit allow, output bit matched, output int idx);
        bit v, alloff, perm;
        logic [63:0] b, l;
        alloff = 1'b1; matched = 1'b0; idx = 0; allow = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_cfg[i][4:3] != 2'd0) alloff = 1'b0;
            if (!matched) begin
                m_range(i, v, b, l);
                if (v && addr >= b && addr <= l) begin
                    matched = 1'b1; idx = i;
                end
            end
        end
        if (typ == 3)     allow = 1'b0;
        else if (matched) begin
            perm  = m_cfg[idx][typ];
            allow = m_cfg[idx][7] ? perm : (priv || perm);
        end else          allow = priv || alloff;
    endfunction

    // ---------------- transaction tasks ----------------
    task automatic wait_ready(input string name);
        int c = 0;
        while (!(wr_ready && req_ready) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check({name, " ready_timeout"}, wr_ready && req_ready, 1);
    endtask

    // exp_stall < 0: take the expected stall from the model.
    task automatic do_write(input bit sel, input int idx, input logic [63:0] d,
                            input int exp_stall, input string name);
        int stall;
        bit eff;
        wait_ready(name);
        wr_valid = 1'b1; wr_sel = sel; wr_idx = idx[IW-1:0]; wr_data = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        eff = m_write(sel, idx, d);
        stall = 0;
        while ((!wr_ready || !req_ready) && stall < N + 8) begin
            stall++;
            @(posedge clk); #1;
        end
        check({name, " stall"}, stall, (exp_stall < 0) ? (eff ? N : 0) : exp_stall);
        $display("[TB] write sel=%0d idx=%0d data=0x%0h stall=%0d", sel, idx, d, stall);
    endtask

    // e_allow < 0: take the expected response from the model.
    task automatic do_query(input logic [63:0] addr, input int typ, input bit priv,
                            input int e_allow, input int e_matched, input int e_idx,
                            input string name);
        bit ma, mm;
        int mi;
        m_query(addr, typ, priv, ma, mm, mi);
        if (e_allow < 0) begin
            e_allow = ma; e_matched = mm; e_idx = mi;
        end
        wait_ready(name);
        req_valid = 1'b1; req_addr = addr[W-1:0]; req_type = typ[1:0]; req_priv_m = priv;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({name, " valid"},   resp_valid,   1);
        check({name, " allow"},   resp_allow,   e_allow);
        check({name, " matched"}, resp_matched, e_matched);
        check({name, " idx"},     resp_idx,     e_idx);
        $display("[TB] query addr=0x%0h type=%0d m=%0d -> allow=%0d matched=%0d idx=%0d",
                 addr, typ, priv, resp_allow, resp_matched, resp_idx);
        @(posedge clk); #1;
        check({name, " valid_pulse"}, resp_valid, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          is_q;
        bit          sel;
        int          idx;
        logic [63:0] data;
        int          stall;
        logic [63:0] addr;
        int          typ;
        bit          priv;
        int          allow;
        int          matched;
        int          ridx;
        string       name;
    } vec_t;

    function automatic vec_t mkw(input bit sel, input int idx, input logic [63:0] d,
                                 input int stall, input string name);
        vec_t v;
        v = '{is_q: 1'b0, sel: sel, idx: idx, data: d, stall: stall, addr: '0, typ: 0,
              priv: 1'b0, allow: 0, matched: 0, ridx: 0, name: name};
        return v;
    endfunction

    function automatic vec_t mkq(input logic [63:0] a, input int typ, input bit priv,
                                 input int allow, input int matched, input int ridx,
                                 input string name);
        vec_t v;
        v = '{is_q: 1'b1, sel: 1'b0, idx: 0, data: '0, stall: 0, addr: a, typ: typ,
              priv: priv, allow: allow, matched: matched, ridx: ridx, name: name};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          sa, sm;
        int          si;
        int          stall;
        logic [63:0] d, a, b, l;
        bit          v;
        int          j;

        tbl.push_back(mkq(64'h1234, 0, 0, 1, 0, 0, "rst_query"));
        tbl.push_back(mkw(1, 0, 64'h1FF, N, "e0_addr"));
        tbl.push_back(mkw(0, 0, 64'h19, N, "e0_cfg"));
        tbl.push_back(mkq(64'hFFF, 0, 0, 1, 1, 0, "e0_top"));
        tbl.push_back(mkq(64'h1000, 0, 0, 0, 0, 0, "e0_above_s"));
        tbl.push_back(mkq(64'h1000, 1, 1, 1, 0, 0, "e0_above_m"));
        tbl.push_back(mkq(64'hFFF, 3, 1, 0, 1, 0, "type3_denied"));
        tbl.push_back(mkw(1, 1, 64'h800, N, "e1_addr"));
        tbl.push_back(mkw(0, 1, 64'h0C, N, "e1_cfg"));
        tbl.push_back(mkq(64'h1800, 2, 0, 1, 1, 1, "tor_fetch"));
        tbl.push_back(mkq(64'h800, 2, 0, 0, 1, 0, "prio_fetch"));
        tbl.push_back(mkq(64'h1FFF, 2, 0, 1, 1, 1, "tor_limit"));
        tbl.push_back(mkq(64'h2000, 2, 0, 0, 0, 0, "tor_above"));
        tbl.push_back(mkw(0, 1, 64'h8C, N, "e1_lock"));
        tbl.push_back(mkw(1, 1, 64'h0, 0, "e1_addr_locked"));
        tbl.push_back(mkw(1, 0, 64'h0, 0, "e0_addr_tor_locked"));
        tbl.push_back(mkq(64'h1800, 0, 1, 0, 1, 1, "locked_m_load"));
        tbl.push_back(mkw(1, 2, 64'h3FFF, N, "e2_addr"));

        m_reset();
        rstn = 1'b0; wr_valid = 1'b0; wr_sel = 1'b0; wr_idx = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; req_type = '0; req_priv_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst wr_ready",     wr_ready,     1);
        check("rst req_ready",    req_ready,    1);
        check("rst resp_valid",   resp_valid,   0);
        check("rst resp_allow",   resp_allow,   0);
        check("rst resp_matched", resp_matched, 0);
        check("rst resp_idx",     resp_idx,     0);
        rstn = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            if (tbl[i].is_q)
                do_query(tbl[i].addr, tbl[i].typ, tbl[i].priv, tbl[i].allow,
                         tbl[i].matched, tbl[i].ridx, tbl[i].name);
            else
                do_write(tbl[i].sel, tbl[i].idx, tbl[i].data, tbl[i].stall, tbl[i].name);
        end

        // Write (entry2 cfg=NAPOT, R=0) and query in the same cycle: old table answers.
        wait_ready("simul");
        wr_valid = 1'b1; wr_sel = 1'b0; wr_idx = 4'd2; wr_data = 64'h18;
        req_valid = 1'b1; req_addr = 56'h10000; req_type = 2'd0; req_priv_m = 1'b0;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        void'(m_write(1'b0, 2, 64'h18));
        check("simul valid",   resp_valid,   1);
        check("simul allow",   resp_allow,   0);
        check("simul matched", resp_matched, 0);
        $display("[TB] simul write+query -> allow=%0d matched=%0d idx=%0d",
                 resp_allow, resp_matched, resp_idx);
        // Next query (M-mode load) held valid: it waits out the recompute.
        req_priv_m = 1'b1;
        stall = 0;
        while (stall < N + 8) begin
            sa = req_ready;
            @(posedge clk); #1;
            if (sa) break;
            stall++;
        end
        req_valid = 1'b0;
        check("stall cycles",   stall,        N);
        check("stall valid",    resp_valid,   1);
        check("stall allow",    resp_allow,   1);
        check("stall matched",  resp_matched, 1);
        check("stall idx",      resp_idx,     2);
        $display("[TB] stalled query stall=%0d -> allow=%0d matched=%0d idx=%0d",
                 stall, resp_allow, resp_matched, resp_idx);

        // Reset during CALC.
        wait_ready("midcalc");
        wr_valid = 1'b1; wr_sel = 1'b0; wr_idx = 4'd3; wr_data = 64'h1B;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midcalc busy", wr_ready, 0);
        rstn = 1'b0;
        #1;
        check("midcalc wr_ready",     wr_ready,     1);
        check("midcalc req_ready",    req_ready,    1);
        check("midcalc resp_valid",   resp_valid,   0);
        check("midcalc resp_allow",   resp_allow,   0);
        check("midcalc resp_matched", resp_matched, 0);
        check("midcalc resp_idx",     resp_idx,     0);
        $display("[TB] reset mid-CALC -> ready=%0d resp_valid=%0d", wr_ready, resp_valid);
        m_reset();
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst ready", req_ready, 1);
        do_query(64'h1234, 0, 0, 1, 0, 0, "post_rst_q");
        do_query(64'h10000, 0, 0, 1, 0, 0, "post_rst_cleared");

        // Randomized phase against the model.
        for (int it = 0; it < 260; it++) begin
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 1) == 0) begin
                    d = 64'($urandom_range(0, 255)) & 64'h9F;
                    if ($urandom_range(0, 15) != 0) d[7] = 1'b0;
                    do_write(1'b0, $urandom_range(0, N - 1), d, -1, "rnd_cfg");
                end else begin
                    case ($urandom_range(0, 9))
                        0:       d = (64'd1 << (W - 2)) - 1;
                        1:       d = {$urandom, $urandom} & ((64'd1 << (W - 2)) - 1);
                        default: d = 64'($urandom_range(0, 'h1000));
                    endcase
                    do_write(1'b1, $urandom_range(0, N - 1), d, -1, "rnd_addr");
                end
            end else begin
                j = $urandom_range(0, N - 1);
                m_range(j, v, b, l);
                case ($urandom_range(0, 5))
                    0: a = b;
                    1: a = l;
                    2: a = b - 1;
                    3: a = l + 1;
                    4: a = {$urandom, $urandom};
                    default: a = 64'($urandom_range(0, 'h5000));
                endcase
                a = a & ((64'd1 << W) - 1);
                do_query(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, 0, 0, "rnd_q");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
